// File: rtl/s298_bist_ctrl.sv
// BIST controller wrapped around the s298 core: an 8-bit LFSR drives G0..G2,
// and a 16-bit MISR compacts the six registered core outputs into a signature.
module s298_bist_ctrl #(
  parameter int unsigned NPAT     = 16,
  parameter int unsigned INIT_CYC = 2,
  parameter logic [7:0]  SEED     = 8'h01,
  parameter logic [15:0] GOLDEN   = 16'h0000
) (
  input  logic        CK,
  input  logic        RSTN,
  input  logic        start,
  input  logic [5:0]  resp,
  output logic        cut_g0,
  output logic        cut_g1,
  output logic        cut_g2,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  typedef enum logic [2:0] {StIdle, StInit, StApply, StFlush, StDone} state_e;

  // An all-zero LFSR would lock up, so a zero seed falls back to 8'h01.
  localparam logic [7:0]  SeedEff  = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [15:0] LastPat  = 16'(NPAT - 1);
  localparam logic [7:0]  LastInit = 8'(INIT_CYC - 1);

  state_e      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [15:0] misr_q, misr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  init_q, init_d;
  logic        cap_en_q, cap_en_d;

  // Next-state logic for the sequencer, LFSR, MISR and counters.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    misr_d   = misr_q;
    cnt_d    = cnt_q;
    init_d   = init_q;
    // Core outputs are registered, so capture lags the applied pattern by one cycle.
    cap_en_d = (state_q == StApply);

    if (cap_en_q) begin
      misr_d = {misr_q[14:0], 1'b0} ^ (misr_q[15] ? 16'h1021 : 16'h0000) ^ {10'b0, resp};
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StInit;
          init_d  = 8'd0;
        end
      end
      StInit: begin
        lfsr_d = SeedEff;
        misr_d = 16'h0000;
        cnt_d  = 16'h0000;
        if (init_q == LastInit) begin
          state_d = StApply;
        end else begin
          init_d = init_q + 8'd1;
        end
      end
      StApply: begin
        lfsr_d = {lfsr_q[6:0], ^(lfsr_q & 8'hB8)};
        if (cnt_q == LastPat) begin
          state_d = StFlush;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StFlush: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= StIdle;
      lfsr_q   <= SeedEff;
      misr_q   <= 16'h0000;
      cnt_q    <= 16'h0000;
      init_q   <= 8'd0;
      cap_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      misr_q   <= misr_d;
      cnt_q    <= cnt_d;
      init_q   <= init_d;
      cap_en_q <= cap_en_d;
    end
  end

  // Output decode from state and flops only; resp and start never reach an output.
  always_comb begin
    cut_g0    = (state_q != StApply) | (&lfsr_q[7:5]);
    cut_g1    = (state_q == StApply) & lfsr_q[0];
    cut_g2    = (state_q == StApply) & lfsr_q[1];
    busy      = (state_q == StInit) | (state_q == StApply) | (state_q == StFlush);
    done      = (state_q == StDone);
    pass      = done & (misr_q == GOLDEN);
    signature = misr_q;
  end

endmodule

// File: tb/tb_s298_bist_ctrl.sv
// Self-checking bench for s298_bist_ctrl: five instances with different
// parameters share clock, reset and resp; each has its own start.
module tb_s298_bist_ctrl;

  localparam int unsigned ANpat = 5;
  localparam int unsigned AInit = 2;

  logic        CK = 1'b0;
  logic        RSTN;
  logic [4:0]  start;
  logic [5:0]  resp;
  logic [4:0]  g0, g1, g2, busy, done, pass;
  logic [15:0] sig [5];
  int          checks = 0;
  int          errors = 0;

  always #5 CK = ~CK;

  s298_bist_ctrl #(.NPAT(ANpat), .INIT_CYC(AInit), .SEED(8'h01), .GOLDEN(16'h0000)) u_a (
    .CK(CK), .RSTN(RSTN), .start(start[0]), .resp(resp), .cut_g0(g0[0]), .cut_g1(g1[0]),
    .cut_g2(g2[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .signature(sig[0]));
  s298_bist_ctrl #(.NPAT(4), .INIT_CYC(2), .SEED(8'h01), .GOLDEN(16'h0000)) u_b (
    .CK(CK), .RSTN(RSTN), .start(start[1]), .resp(resp), .cut_g0(g0[1]), .cut_g1(g1[1]),
    .cut_g2(g2[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .signature(sig[1]));
  s298_bist_ctrl #(.NPAT(1), .INIT_CYC(2), .SEED(8'h01), .GOLDEN(16'h0000)) u_c (
    .CK(CK), .RSTN(RSTN), .start(start[2]), .resp(resp), .cut_g0(g0[2]), .cut_g1(g1[2]),
    .cut_g2(g2[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]), .signature(sig[2]));
  s298_bist_ctrl #(.NPAT(2), .INIT_CYC(2), .SEED(8'h01), .GOLDEN(16'h0003)) u_d (
    .CK(CK), .RSTN(RSTN), .start(start[3]), .resp(resp), .cut_g0(g0[3]), .cut_g1(g1[3]),
    .cut_g2(g2[3]), .busy(busy[3]), .done(done[3]), .pass(pass[3]), .signature(sig[3]));
  s298_bist_ctrl #(.NPAT(2), .INIT_CYC(2), .SEED(8'h01), .GOLDEN(16'h0004)) u_e (
    .CK(CK), .RSTN(RSTN), .start(start[4]), .resp(resp), .cut_g0(g0[4]), .cut_g1(g1[4]),
    .cut_g2(g2[4]), .busy(busy[4]), .done(done[4]), .pass(pass[4]), .signature(sig[4]));

  // Reference model: LFSR successor from the tap rule, MISR as polynomial arithmetic.
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    logic fb;
    fb = l[7] ^ l[5] ^ l[4] ^ l[3];
    return 8'((int'(l) * 2) % 256) | {7'b0, fb};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [5:0] r);
    logic [15:0] n;
    n = 16'((int'(m) * 2) % 65536);
    if (int'(m) >= 32768) n = n ^ 16'h1021;
    return n ^ {10'b0, r};
  endfunction

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  // Bounded wait for done on one instance; edges = -1 when the bound expires.
  task automatic wait_done(input int idx, output int edges);
    edges = 0;
    while (done[idx] !== 1'b1 && edges < 50) begin
      step();
      edges++;
    end
    if (done[idx] !== 1'b1) edges = -1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if ({g0[0], g1[0], g2[0]} !== 3'b100) begin
      errors++; $display("FAIL rst_cut got %b want 100", {g0[0], g1[0], g2[0]}); end
    checks++; if ({busy[0], done[0], pass[0]} !== 3'b000) begin
      errors++; $display("FAIL rst_flags got %b want 000", {busy[0], done[0], pass[0]}); end
    checks++; if (sig[0] !== 16'h0000) begin
      errors++; $display("FAIL rst_sig got %h want 0000", sig[0]); end
    #10 RSTN = 1'b1;
    step();
    // Mid-APPLY reset with nonzero captured responses.
    resp = 6'h3f;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (5) step();
    checks++; if (busy[0] !== 1'b1 || sig[0] === 16'h0000) begin
      errors++; $display("FAIL pre_rst busy %b sig %h want busy 1 sig nonzero", busy[0], sig[0]); end
    RSTN = 1'b0;
    #1;
    checks++; if ({g0[0], g1[0], g2[0], busy[0], done[0], pass[0]} !== 6'b100000) begin
      errors++; $display("FAIL midrst_outs got %b want 100000",
                         {g0[0], g1[0], g2[0], busy[0], done[0], pass[0]}); end
    checks++; if (sig[0] !== 16'h0000) begin
      errors++; $display("FAIL midrst_sig got %h want 0000", sig[0]); end
    #1 RSTN = 1'b1;
    step();
    checks++; if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      errors++; $display("FAIL post_rst_idle busy %b done %b want 0 0", busy[0], done[0]); end
  endtask

  task automatic test_sequence();
    logic [4:0] e1, e2;
    int ed;
    e1 = 5'b10001;  // element j at bit 4-j
    e2 = 5'b01000;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (AInit) step();
    for (int j = 0; j < 5; j++) begin
      checks++; if ({g0[0], g1[0], g2[0]} !== {1'b0, e1[4-j], e2[4-j]}) begin
        errors++; $display("FAIL seq_pat%0d got %b want %b", j, {g0[0], g1[0], g2[0]},
                           {1'b0, e1[4-j], e2[4-j]}); end
      step();
    end
    wait_done(0, ed);
    checks++; if (ed < 0) begin errors++; $display("FAIL seq_done got timeout want done"); end
  endtask

  task automatic test_latency();
    int n, bc;
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    n = 0;
    bc = 0;
    while (done[1] !== 1'b1 && n < 50) begin
      if (busy[1] === 1'b1) bc++;
      step();
      n++;
    end
    checks++; if (n !== 7) begin errors++; $display("FAIL lat_done got %0d want 7", n); end
    checks++; if (bc !== 7) begin errors++; $display("FAIL lat_busy got %0d want 7", bc); end
  endtask

  task automatic test_random(input int runs);
    logic [7:0]  l;
    logic [15:0] m;
    logic        eg0, eg1, eg2;
    int          last;
    last = AInit + ANpat + 2;
    for (int r = 0; r < runs; r++) begin
      resp = 6'($urandom);
      start[0] = 1'b1;
      step();
      start[0] = 1'b0;
      l = 8'h01;
      m = 16'h0000;
      for (int i = 0; i <= last; i++) begin
        if (i >= AInit && i < AInit + ANpat) begin
          eg0 = l[7] & l[6] & l[5];
          eg1 = l[0];
          eg2 = l[1];
          l = lfsr_next(l);
        end else begin
          eg0 = 1'b1;
          eg1 = 1'b0;
          eg2 = 1'b0;
        end
        checks++; if ({g0[0], g1[0], g2[0]} !== {eg0, eg1, eg2}) begin
          errors++; $display("FAIL rnd_cut r%0d i%0d got %b want %b", r, i,
                             {g0[0], g1[0], g2[0]}, {eg0, eg1, eg2}); end
        checks++; if ({busy[0], done[0]} !== {i <= AInit + ANpat, i > AInit + ANpat}) begin
          errors++; $display("FAIL rnd_flags r%0d i%0d got %b want %b", r, i, {busy[0], done[0]},
                             {i <= AInit + ANpat, i > AInit + ANpat}); end
        if (i > AInit + ANpat) begin
          checks++; if (sig[0] !== m) begin
            errors++; $display("FAIL rnd_sig r%0d i%0d got %h want %h", r, i, sig[0], m); end
          checks++; if (pass[0] !== (m == 16'h0000)) begin
            errors++; $display("FAIL rnd_pass r%0d got %b want %b", r, pass[0], m == 16'h0000); end
        end
        resp = 6'($urandom);
        if (i > AInit && i <= AInit + ANpat) m = misr_step(m, resp);
        if (i < last) step();
      end
    end
  endtask

  task automatic test_compaction();
    int ed;
    resp = 6'h01;
    start[4:2] = 3'b111;
    step();
    start[4:2] = 3'b000;
    wait_done(3, ed);
    checks++; if (ed < 0) begin errors++; $display("FAIL cmp_done got timeout want done"); end
    checks++; if (sig[2] !== 16'h0001 || done[2] !== 1'b1) begin
      errors++; $display("FAIL cmp_n1 got %h done %b want 0001 done 1", sig[2], done[2]); end
    checks++; if (sig[3] !== 16'h0003 || pass[3] !== 1'b1) begin
      errors++; $display("FAIL cmp_n2_pass got %h pass %b want 0003 pass 1", sig[3], pass[3]); end
    checks++; if (sig[4] !== 16'h0003 || pass[4] !== 1'b0 || done[4] !== 1'b1) begin
      errors++; $display("FAIL cmp_n2_fail got %h pass %b want 0003 pass 0", sig[4], pass[4]); end
    resp = 6'h00;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    wait_done(0, ed);
    checks++; if (ed < 0 || sig[0] !== 16'h0000 || pass[0] !== 1'b1) begin
      errors++; $display("FAIL cmp_zero got %h pass %b want 0000 pass 1", sig[0], pass[0]); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] m;
    int ed;
    resp = 6'h3f;
    m = 16'h0000;
    for (int k = 0; k < ANpat; k++) m = misr_step(m, 6'h3f);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (AInit + 1) step();
    start[0] = 1'b1;  // mid-APPLY request must be ignored
    step();
    start[0] = 1'b0;
    wait_done(0, ed);
    checks++; if (ed !== 4) begin errors++; $display("FAIL rs_ignore got %0d want 4", ed); end
    checks++; if (sig[0] !== m) begin errors++; $display("FAIL rs_sig got %h want %h", sig[0], m); end
    start[0] = 1'b1;  // held through DONE
    step();
    checks++; if (done[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++; $display("FAIL rs_rerun done %b busy %b want 0 1", done[0], busy[0]); end
    step();
    start[0] = 1'b0;
    checks++; if (sig[0] !== 16'h0000) begin
      errors++; $display("FAIL rs_clear got %h want 0000", sig[0]); end
    wait_done(0, ed);
    checks++; if (ed !== 7) begin errors++; $display("FAIL rs_second got %0d want 7", ed); end
    checks++; if (sig[0] !== m) begin errors++; $display("FAIL rs_sig2 got %h want %h", sig[0], m); end
  endtask

  initial begin
    RSTN  = 1'b0;
    start = 5'b0;
    resp  = 6'h00;
    test_reset();
    test_sequence();
    test_latency();
    test_random(4);
    test_compaction();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
